interp_seq: RTL



---
 rtl/interp_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/interp_seq.sv
// Pilot-pair interpolation sequencer: streams S_k = (6-k)*hA + k*hB for k = 0..KMAX.
// Define INTERP_EXTRAP_EN to extend the walk to k = 11 for band-edge extrapolation.
//
// state | meaning
// IDLE  | waiting for a pilot pair, in_ready high
// LOAD  | derive 6*hA and hB-hA from the latched pair
// RUN   | present acc as beat k, step by diff on each accepted beat
module interp_seq #(
  parameter int W  = 16,
  parameter int OW = W + 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  h_a,
  input  logic signed [W-1:0]  h_b,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_data,
  output logic [3:0]           out_idx,
  output logic                 out_last,
  output logic                 busy
);

`ifdef INTERP_EXTRAP_EN
  localparam logic [3:0] KMAX = 4'd11;
`else
  localparam logic [3:0] KMAX = 4'd5;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_nxt;

  logic signed [W-1:0]  ha_q, hb_q;
  logic signed [W:0]    diff;
  logic signed [OW-1:0] acc;
  logic [3:0]           k;
  logic                 at_kmax;
  logic [OW-1:0]        ha_ext;
  logic [OW-1:0]        ha6;
  logic [OW-1:0]        diff_ext;

  assign at_kmax  = (k == KMAX);
  assign ha_ext   = {{(OW-W){ha_q[W-1]}}, ha_q};
  // 6*hA as (hA<<2)+(hA<<1); OW leaves headroom so nothing is lost
  assign ha6      = (ha_ext << 2) + (ha_ext << 1);
  assign diff_ext = {{(OW-W-1){diff[W]}}, diff};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (out_ready && at_kmax) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ha_q <= '0;
      hb_q <= '0;
      diff <= '0;
      acc  <= '0;
      k    <= '0;
    end else if (flush) begin
      k <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ha_q <= h_a;
            hb_q <= h_b;
          end
        end
        LOAD: begin
          diff <= {hb_q[W-1], hb_q} - {ha_q[W-1], ha_q};
          acc  <= ha6;
          k    <= '0;
        end
        RUN: begin
          if (out_ready && !at_kmax) begin
            acc <= acc + diff_ext;
            k   <= k + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == RUN);
  assign out_data  = acc;
  assign out_idx   = k;
  assign out_last  = (state == RUN) && at_kmax;

endmodule
